cmd_scheduler: RTL and testbench
================================

Name: cmd_scheduler

Overview:
- Shares the single CMD line engine (command/response serialiser plus SD physical layer) between NUM_REQ independent command sources, e.g. register-interface host commands and the automatic init/CMD12 sequencer.
- Arbitrates round-robin, launches one command at a time, and collects the response and completion handshakes from the engine.
- Returns a one-cycle completion to the granted requester, with a watchdog guarding against a stalled engine.
- Sits between the requester logic and the CMD block, on the system clock domain.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- GW, 1, grant index width; must be ≥ clog2(NUM_REQ).
- WD_CYCLES, 65535, watchdog limit in clock cycles from launch to completion.
- WD_W, 16, watchdog counter width; must satisfy 2^WD_W > WD_CYCLES.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command pending; level, held until req_done.
- req_index  in  6*NUM_REQ  per-requester command index; slice i is [6i+5:6i].
- req_argument  in  32*NUM_REQ  per-requester argument; slice i is [32i+31:32i].
- req_timeout_en  in  NUM_REQ  per-requester timeout enable.
- req_no_response  in  NUM_REQ  per-requester flag: command expects no response.
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- resp_data  out  128  captured response, held until the next capture.
- resp_error  out  1  set when completion came from the watchdog; valid with req_done.
- busy  out  1  high whenever the state is not IDLE.
- grant_id  out  GW  index of the current or last granted requester.
- new_command  out  1  to engine.
- cmd_index  out  6  to engine.
- cmd_argument  out  32  to engine.
- timeout_enable  out  1  to engine.
- no_response  out  1  to engine.
- response  in  128  from engine.
- enable_response  in  1  from engine: response available.
- ack_response  out  1  to engine.
- enable_command_complete  in  1  from engine: command finished.
- ack_command_complete  out  1  to engine.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs are 0: resp_data=0, grant_id=0, req_done=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
  - Watchdog counter is cleared.
  - Reset asserted mid-command abandons the command with no req_done.
- State machine: IDLE → LAUNCH → WAIT → CLOSE → DONE → IDLE.
- IDLE:
  - Selects the first req_valid bit searching last+1, last+2, … modulo NUM_REQ.
  - On a winner: latches its index/argument/timeout/no_response into the output registers, sets grant_id and last, and moves to LAUNCH.
  - Requests asserted simultaneously are resolved purely by the pointer.
- LAUNCH:
  - new_command=1, held level through WAIT.
  - Clears the watchdog and moves to WAIT on the next cycle.
- WAIT:
  - Watchdog increments each cycle.
  - If enable_response=1 and ack_response is not already high: capture response into resp_data, then pulse ack_response for exactly one cycle.
  - Captures only once per command; further enable_response while acked is ignored.
  - If enable_command_complete=1: new_command drops and the state moves to CLOSE.
  - Completion and response in the same cycle: capture, ack_response, and the move to CLOSE all happen together.
  - If watchdog reaches WD_CYCLES-1 with no completion: new_command=0, error flag set, go directly to DONE without the CLOSE handshake.
- CLOSE:
  - ack_command_complete=1, held until enable_command_complete samples 0, then go to DONE.
  - Latency from enable_command_complete rising to req_done is 3 cycles minimum.
- DONE:
  - req_done[grant_id]=1 for one cycle; resp_error = error flag.
  - Error flag clears and the state returns to IDLE.
- resp_data contents:
  - A command with no_response=1 leaves resp_data unchanged.
  - A watchdog abort keeps the last value.
- Request changes and withdrawal:
  - req_* inputs changing after grant have no effect; the command uses the latched copy.
  - A requester dropping req_valid mid-command still receives req_done.
- Back-to-back commands:
  - The minimum gap between new_command falling and the next new_command rising is 2 cycles (DONE, IDLE).
  - Another requester pending is granted from IDLE on the cycle after DONE.

Decomposition:
- Shared package holds:
  - State encoding localparams (IDLE=0, LAUNCH=1, WAIT=2, CLOSE=3, DONE=4).
  - Command field widths: INDEX_W=6, ARG_W=32, RESP_W=128.
- One natural sub-module: rr_arbiter (combinational priority search plus registered pointer, parameter NUM_REQ).
- The FSM, watchdog and datapath registers stay in cmd_scheduler.

Test Plan:
- Reset, then req_valid=01 with index=8 and argument=0x000001AA → cmd_index=8 and cmd_argument=0x1AA.
  - Engine model raises enable_response with response=0x…1AA, then enable_command_complete.
  - Required: new_command high from cycle 2, a single ack_response pulse, resp_data=0x…1AA, req_done=01 exactly once, resp_error=0.
- req_valid=11 held continuously → grants alternate 0,1,0,1; each requester's index appears in turn; no requester is granted twice in a row.
- no_response=1 command, engine gives completion only → no ack_response, resp_data keeps its prior value, req_done pulses.
- Engine never completes, WD_CYCLES=16 → new_command drops 16 cycles after LAUNCH, req_done with resp_error=1, no ack_command_complete; the next request proceeds normally.
- enable_response and enable_command_complete rise on the same cycle → response captured and acked once; ack_command_complete held until enable_command_complete falls; then req_done.
- Reset asserted during WAIT → all outputs 0 asynchronously, no req_done; after release, a pending req_valid=10 is granted to requester 0 first only if bit 0 is set, otherwise to requester 1.

Source files
------------

// File: rtl/cmd_scheduler_pkg.sv
// Shared types and field widths for the CMD line scheduler.
package cmd_scheduler_pkg;

    localparam int unsigned INDEX_W = 6;
    localparam int unsigned ARG_W   = 32;
    localparam int unsigned RESP_W  = 128;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CLOSE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/cmd_scheduler_if.sv
// Handshake bundle between the scheduler and the shared CMD line engine.
interface cmd_scheduler_if;
    import cmd_scheduler_pkg::*;

    logic               new_command;
    logic [INDEX_W-1:0] cmd_index;
    logic [ARG_W-1:0]   cmd_argument;
    logic               timeout_enable;
    logic               no_response;
    logic [RESP_W-1:0]  response;
    logic               enable_response;
    logic               ack_response;
    logic               enable_command_complete;
    logic               ack_command_complete;

    modport master (
        output new_command, cmd_index, cmd_argument, timeout_enable, no_response,
        output ack_response, ack_command_complete,
        input  response, enable_response, enable_command_complete
    );

    modport slave (
        input  new_command, cmd_index, cmd_argument, timeout_enable, no_response,
        input  ack_response, ack_command_complete,
        output response, enable_response, enable_command_complete
    );

endinterface

// File: rtl/cmd_scheduler_rr_arbiter.sv
// Round-robin requester selection: combinational search from last+1, registered pointer.
module cmd_scheduler_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned GW      = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               take,
    output logic               gnt_valid,
    output logic [GW-1:0]      gnt_idx
);

    logic [GW-1:0] last_q, last_d;
    logic [GW-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = GW'((32'(last_q) + off) % NUM_REQ);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (take) begin
            last_d = gnt_idx;
        end
    end

    // Pointer starts on the highest index so requester 0 wins the first arbitration.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= GW'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/cmd_scheduler.sv
// Shares one CMD line engine among NUM_REQ command sources, one command at a time,
// with a watchdog that aborts a command the engine never completes.
module cmd_scheduler
    import cmd_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned GW        = 1,
    parameter int unsigned WD_CYCLES = 65535,
    parameter int unsigned WD_W      = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [INDEX_W*NUM_REQ-1:0] req_index,
    input  logic [ARG_W*NUM_REQ-1:0]   req_argument,
    input  logic [NUM_REQ-1:0]         req_timeout_en,
    input  logic [NUM_REQ-1:0]         req_no_response,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [RESP_W-1:0]          resp_data,
    output logic                       resp_error,
    output logic                       busy,
    output logic [GW-1:0]              grant_id,
    cmd_scheduler_if.master            eng
);

    state_t             state_q, state_d;
    logic               new_command_q, new_command_d;
    logic [INDEX_W-1:0] cmd_index_q, cmd_index_d;
    logic [ARG_W-1:0]   cmd_argument_q, cmd_argument_d;
    logic               timeout_enable_q, timeout_enable_d;
    logic               no_response_q, no_response_d;
    logic               ack_response_q, ack_response_d;
    logic               ack_cc_q, ack_cc_d;
    logic               resp_seen_q, resp_seen_d;
    logic [RESP_W-1:0]  resp_data_q, resp_data_d;
    logic               resp_error_q, resp_error_d;
    logic               busy_q, busy_d;
    logic [GW-1:0]      grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0] req_done_q, req_done_d;
    logic [WD_W-1:0]    wd_q, wd_d;

    logic               gnt_valid;
    logic [GW-1:0]      gnt_idx;
    logic               take;

    assign take = (state_q == ST_IDLE) && gnt_valid;

    cmd_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (req_valid),
        .take      (take),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d          = state_q;
        new_command_d    = new_command_q;
        cmd_index_d      = cmd_index_q;
        cmd_argument_d   = cmd_argument_q;
        timeout_enable_d = timeout_enable_q;
        no_response_d    = no_response_q;
        ack_response_d   = 1'b0;
        ack_cc_d         = ack_cc_q;
        resp_seen_d      = resp_seen_q;
        resp_data_d      = resp_data_q;
        resp_error_d     = resp_error_q;
        grant_id_d       = grant_id_q;
        req_done_d       = '0;
        wd_d             = wd_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    cmd_index_d      = req_index[gnt_idx*INDEX_W +: INDEX_W];
                    cmd_argument_d   = req_argument[gnt_idx*ARG_W +: ARG_W];
                    timeout_enable_d = req_timeout_en[gnt_idx];
                    no_response_d    = req_no_response[gnt_idx];
                    grant_id_d       = gnt_idx;
                    new_command_d    = 1'b1;
                    state_d          = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wd_d        = '0;
                resp_seen_d = 1'b0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                wd_d = wd_q + 1'b1;
                // One capture per command; a response still held after the ack is ignored.
                if (eng.enable_response && !ack_response_q && !resp_seen_q && !no_response_q) begin
                    resp_data_d    = eng.response;
                    ack_response_d = 1'b1;
                    resp_seen_d    = 1'b1;
                end
                if (eng.enable_command_complete) begin
                    new_command_d = 1'b0;
                    ack_cc_d      = 1'b1;
                    state_d       = ST_CLOSE;
                end else if (wd_q == WD_W'(WD_CYCLES - 1)) begin
                    new_command_d          = 1'b0;
                    resp_error_d           = 1'b1;
                    req_done_d[grant_id_q] = 1'b1;
                    state_d                = ST_DONE;
                end
            end
            ST_CLOSE: begin
                if (!eng.enable_command_complete) begin
                    ack_cc_d               = 1'b0;
                    req_done_d[grant_id_q] = 1'b1;
                    state_d                = ST_DONE;
                end
            end
            ST_DONE: begin
                resp_error_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            new_command_q    <= 1'b0;
            cmd_index_q      <= '0;
            cmd_argument_q   <= '0;
            timeout_enable_q <= 1'b0;
            no_response_q    <= 1'b0;
            ack_response_q   <= 1'b0;
            ack_cc_q         <= 1'b0;
            resp_seen_q      <= 1'b0;
            resp_data_q      <= '0;
            resp_error_q     <= 1'b0;
            busy_q           <= 1'b0;
            grant_id_q       <= '0;
            req_done_q       <= '0;
            wd_q             <= '0;
        end else begin
            state_q          <= state_d;
            new_command_q    <= new_command_d;
            cmd_index_q      <= cmd_index_d;
            cmd_argument_q   <= cmd_argument_d;
            timeout_enable_q <= timeout_enable_d;
            no_response_q    <= no_response_d;
            ack_response_q   <= ack_response_d;
            ack_cc_q         <= ack_cc_d;
            resp_seen_q      <= resp_seen_d;
            resp_data_q      <= resp_data_d;
            resp_error_q     <= resp_error_d;
            busy_q           <= busy_d;
            grant_id_q       <= grant_id_d;
            req_done_q       <= req_done_d;
            wd_q             <= wd_d;
        end
    end

    assign req_done                 = req_done_q;
    assign resp_data                = resp_data_q;
    assign resp_error               = resp_error_q;
    assign busy                     = busy_q;
    assign grant_id                 = grant_id_q;
    assign eng.new_command          = new_command_q;
    assign eng.cmd_index            = cmd_index_q;
    assign eng.cmd_argument         = cmd_argument_q;
    assign eng.timeout_enable       = timeout_enable_q;
    assign eng.no_response          = no_response_q;
    assign eng.ack_response         = ack_response_q;
    assign eng.ack_command_complete = ack_cc_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Scoreboard bench for cmd_scheduler with a behavioural CMD engine model.
module tb_cmd_scheduler;

    localparam int unsigned WDC = 16;
    localparam int MODE_NORMAL = 0;
    localparam int MODE_NORESP = 1;
    localparam int MODE_HANG   = 2;
    localparam int MODE_SAME   = 3;

    typedef struct {
        int           id;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic         to;
        logic         nr;
        logic         err;
        logic [127:0] resp;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   req_valid = '0;
    logic [11:0]  req_index = '0;
    logic [63:0]  req_argument = '0;
    logic [1:0]   req_timeout_en = '0;
    logic [1:0]   req_no_response = '0;
    logic [1:0]   req_done;
    logic [127:0] resp_data;
    logic         resp_error;
    logic         busy;
    logic [0:0]   grant_id;

    cmd_scheduler_if eng_if();

    cmd_scheduler #(
        .NUM_REQ   (2),
        .GW        (1),
        .WD_CYCLES (WDC),
        .WD_W      (5)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_index       (req_index),
        .req_argument    (req_argument),
        .req_timeout_en  (req_timeout_en),
        .req_no_response (req_no_response),
        .req_done        (req_done),
        .resp_data       (resp_data),
        .resp_error      (resp_error),
        .busy            (busy),
        .grant_id        (grant_id),
        .eng             (eng_if)
    );

    initial forever #5 clock = ~clock;

    int           n_checks = 0;
    int           n_fail   = 0;
    exp_t         sb[$];
    logic [127:0] model_resp = '0;
    int           eng_mode = MODE_NORMAL;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] resp_of(input logic [5:0] idx, input logic [31:0] arg);
        return {26'h0, idx, 64'h0123_4567_89AB_CDEF, arg};
    endfunction

    task automatic drive_req(input int id, input logic [5:0] idx, input logic [31:0] arg,
                             input logic to, input logic nr);
        req_index[id*6 +: 6]     = idx;
        req_argument[id*32 +: 32] = arg;
        req_timeout_en[id]       = to;
        req_no_response[id]      = nr;
        req_valid[id]            = 1'b1;
    endtask

    task automatic expect_cmd(input int id, input logic [5:0] idx, input logic [31:0] arg,
                              input logic to, input logic nr, input logic err);
        exp_t e;
        if (!nr && !err) model_resp = resp_of(idx, arg);
        e.id = id; e.idx = idx; e.arg = arg; e.to = to; e.nr = nr; e.err = err;
        e.resp = model_resp;
        sb.push_back(e);
    endtask

    task automatic issue(input int id, input logic [5:0] idx, input logic [31:0] arg,
                         input logic to, input logic nr, input int mode);
        eng_mode = mode;
        expect_cmd(id, idx, arg, to, nr, mode == MODE_HANG);
        drive_req(id, idx, arg, to, nr);
    endtask

    // Waits for n completions; the last one withdraws every request before IDLE re-arbitrates.
    task automatic run_done(input int n, input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            @(negedge clock);
            if (req_done != 2'b00) begin
                seen++;
                if (seen == n) req_valid = '0;
            end
        end
        if (seen < n) check_eq("done_timeout", seen, n);
    endtask

    // Engine model: responds a fixed number of cycles after new_command, per mode.
    initial begin
        int   ecnt = 0;
        logic edone = 1'b0;
        eng_if.response                = '0;
        eng_if.enable_response         = 1'b0;
        eng_if.enable_command_complete = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                eng_if.enable_response         = 1'b0;
                eng_if.enable_command_complete = 1'b0;
                ecnt  = 0;
                edone = 1'b0;
            end else begin
                if (eng_if.enable_response && eng_if.ack_response)
                    eng_if.enable_response = 1'b0;
                if (eng_if.enable_command_complete && eng_if.ack_command_complete)
                    eng_if.enable_command_complete = 1'b0;
                if (eng_if.new_command && !edone) begin
                    ecnt++;
                    case (eng_mode)
                        MODE_NORMAL: begin
                            if (ecnt == 2) begin
                                eng_if.response        = resp_of(eng_if.cmd_index, eng_if.cmd_argument);
                                eng_if.enable_response = 1'b1;
                            end
                            if (ecnt == 4) begin
                                eng_if.enable_command_complete = 1'b1;
                                edone = 1'b1;
                            end
                        end
                        MODE_NORESP: begin
                            if (ecnt == 3) begin
                                eng_if.enable_command_complete = 1'b1;
                                edone = 1'b1;
                            end
                        end
                        MODE_SAME: begin
                            if (ecnt == 2) begin
                                eng_if.response                = resp_of(eng_if.cmd_index, eng_if.cmd_argument);
                                eng_if.enable_response         = 1'b1;
                                eng_if.enable_command_complete = 1'b1;
                                edone = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else if (!eng_if.new_command && !eng_if.enable_command_complete) begin
                    ecnt  = 0;
                    edone = 1'b0;
                end
            end
        end
    end

    // Launch and completion monitor against the scoreboard.
    initial begin
        logic prev_nc = 1'b0;
        int   nc_cycles = 0;
        int   ack_cnt = 0;
        logic ack_cc_seen = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (eng_if.new_command && !prev_nc) begin
                nc_cycles   = 0;
                ack_cnt     = 0;
                ack_cc_seen = 1'b0;
                if (sb.size() != 0) begin
                    e = sb[0];
                    check_eq("grant_id", grant_id, e.id);
                    check_eq("cmd_index", eng_if.cmd_index, e.idx);
                    check_eq("cmd_argument", eng_if.cmd_argument, e.arg);
                    check_eq("timeout_enable", eng_if.timeout_enable, e.to);
                    check_eq("no_response", eng_if.no_response, e.nr);
                end
            end
            if (eng_if.new_command) nc_cycles++;
            if (eng_if.ack_response) ack_cnt++;
            if (eng_if.ack_command_complete) ack_cc_seen = 1'b1;
            prev_nc = eng_if.new_command;
            if (req_done != 2'b00) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", req_done, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("req_done", req_done, 2'b01 << e.id);
                    check_eq("resp_data", resp_data, e.resp);
                    check_eq("resp_error", resp_error, e.err);
                    check_eq("ack_resp_count", ack_cnt, (e.nr || e.err) ? 0 : 1);
                    check_eq("ack_cc_seen", ack_cc_seen, !e.err);
                    // Abort path: one LAUNCH cycle plus WDC cycles in WAIT.
                    if (e.err) check_eq("wd_nc_cycles", nc_cycles, WDC + 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        @(negedge clock);
        check_eq("rst_req_done", req_done, 0);
        check_eq("rst_resp_data", resp_data, 0);
        check_eq("rst_resp_error", resp_error, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant_id", grant_id, 0);
        check_eq("rst_new_command", eng_if.new_command, 0);
        check_eq("rst_ack_response", eng_if.ack_response, 0);
        check_eq("rst_ack_cc", eng_if.ack_command_complete, 0);
        reset = 1'b0;
        @(negedge clock);

        // Basic command; requester fields change after grant and must be ignored.
        issue(0, 6'd8, 32'h0000_01AA, 1'b1, 1'b0, MODE_NORMAL);
        @(negedge clock);
        check_eq("launch_new_command", eng_if.new_command, 1);
        check_eq("launch_busy", busy, 1);
        req_index[5:0]     = 6'h3F;
        req_argument[31:0] = 32'hFFFF_FFFF;
        req_timeout_en[0]  = 1'b0;
        run_done(1, 40);
        @(negedge clock);
        check_eq("idle_busy", busy, 0);

        // No-response command keeps the previous resp_data.
        issue(1, 6'd12, 32'hDEAD_BEEF, 1'b0, 1'b1, MODE_NORESP);
        run_done(1, 40);
        @(negedge clock);

        // Both pending continuously: grants alternate 0,1,0,1.
        eng_mode = MODE_NORMAL;
        drive_req(0, 6'd17, 32'h1111_0000, 1'b1, 1'b0);
        drive_req(1, 6'd41, 32'h2222_0000, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            expect_cmd(0, 6'd17, 32'h1111_0000, 1'b1, 1'b0, 1'b0);
            expect_cmd(1, 6'd41, 32'h2222_0000, 1'b0, 1'b0, 1'b0);
        end
        run_done(4, 200);
        @(negedge clock);

        // Engine never completes: watchdog abort, then a normal command.
        issue(1, 6'd13, 32'h5A5A_0001, 1'b1, 1'b0, MODE_HANG);
        run_done(1, 60);
        @(negedge clock);
        issue(0, 6'd2, 32'h0000_0002, 1'b0, 1'b0, MODE_NORMAL);
        run_done(1, 40);
        @(negedge clock);

        // Response and completion on the same cycle.
        issue(1, 6'd55, 32'h0BAD_F00D, 1'b1, 1'b0, MODE_SAME);
        run_done(1, 40);
        @(negedge clock);

        // Reset during WAIT abandons the command with no req_done.
        eng_mode = MODE_HANG;
        drive_req(0, 6'd9, 32'h0000_0099, 1'b1, 1'b0);
        for (int i = 0; i < 20 && !eng_if.new_command; i++) @(negedge clock);
        repeat (4) @(negedge clock);
        check_eq("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_eq("async_new_command", eng_if.new_command, 0);
        check_eq("async_busy", busy, 0);
        check_eq("async_resp_data", resp_data, 0);
        check_eq("async_grant_id", grant_id, 0);
        check_eq("async_req_done", req_done, 0);
        model_resp = '0;
        req_valid  = '0;
        drive_req(1, 6'd33, 32'h3300_0033, 1'b0, 1'b0);
        eng_mode = MODE_NORMAL;
        repeat (2) @(negedge clock);
        expect_cmd(1, 6'd33, 32'h3300_0033, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        run_done(1, 40);
        repeat (3) @(negedge clock);

        check_eq("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
